// File: rtl/rd_xfr_pkg.sv
// Shared types and constants for the RD transfer scheduler.
// BUF_STAT layout is {timeout, parity_err, word_count[AW:0]}; flag positions depend on AW.
package rd_xfr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_FIRST,
    S_XFER,
    S_CLOSE
  } state_t;

  localparam int MEM_SIZE_DEF      = 2048;
  localparam int TRIG_WIDTH_DEF    = 4;
  localparam int START_TIMEOUT_DEF = 256;
  localparam int WORD_TIMEOUT_DEF  = 64;

  localparam int STAT_CNT_LSB = 0;

  function automatic int stat_perr_bit(input int aw);
    return aw + 1;
  endfunction

  function automatic int stat_to_bit(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/rd_xfr_sched_if.sv
// Trigger, deserializer, capture-memory and software-status signals of the RD scheduler.
interface rd_xfr_sched_if #(parameter int AW = 11);
  logic          enable;
  logic          evt_trig;
  logic          rx_valid;
  logic [11:0]   rx_data0;
  logic [11:0]   rx_data1;
  logic [1:0]    rx_perr;
  logic [1:0]    buf_release;
  logic          rd_enable;
  logic          rd_trigger;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [23:0]   wr_data;
  logic          busy;
  logic          xfr_done;
  logic [1:0]    buf_full;
  logic [AW+2:0] buf_stat0;
  logic [AW+2:0] buf_stat1;
  logic [7:0]    missed_cnt;

  modport master (
    output enable, evt_trig, rx_valid, rx_data0, rx_data1, rx_perr, buf_release,
    input  rd_enable, rd_trigger, wr_en, wr_addr, wr_data, busy, xfr_done,
           buf_full, buf_stat0, buf_stat1, missed_cnt
  );

  modport slave (
    input  enable, evt_trig, rx_valid, rx_data0, rx_data1, rx_perr, buf_release,
    output rd_enable, rd_trigger, wr_en, wr_addr, wr_data, busy, xfr_done,
           buf_full, buf_stat0, buf_stat1, missed_cnt
  );
endinterface

// File: rtl/rd_buf_tracker.sv
// Ping-pong buffer bookkeeping: full flags, latched status, software release
// and choice of the next buffer to fill.
module rd_buf_tracker #(
  parameter int AW = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_close,
  input  logic                 i_close_buf,
  input  logic [AW+2:0]        i_close_stat,
  input  logic [1:0]           i_release,
  output logic [1:0]           o_full,
  output logic [1:0][AW+2:0]   o_stat,
  output logic                 o_sel,
  output logic                 o_avail
);

  logic [1:0]         r_full;
  logic [1:0][AW+2:0] r_stat;
  logic               r_last;
  logic               w_pref;

  // Close and release of different buffers in one cycle both land; the
  // buffer being closed is never full, so a release of it is a no-op anyway.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= '0;
      r_stat <= '0;
      r_last <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_close && (i_close_buf == 1'(i))) begin
          r_full[i] <= 1'b1;
          r_stat[i] <= i_close_stat;
        end else if (i_release[i] && r_full[i]) begin
          r_full[i] <= 1'b0;
          r_stat[i] <= '0;
        end
      end
      if (i_close) r_last <= i_close_buf;
    end
  end

  assign w_pref  = ~r_last;
  assign o_sel   = r_full[w_pref] ? r_last : w_pref;
  assign o_avail = ~&r_full;
  assign o_full  = r_full;
  assign o_stat  = r_stat;

endmodule

// File: rtl/rd_xfr_sched.sv
// RD link transfer scheduler: issues RD trigger pulses and steers each returning
// transfer into a free capture buffer, closing on word count or timeout.
module rd_xfr_sched
  import rd_xfr_pkg::*;
#(
  parameter int MEM_SIZE      = MEM_SIZE_DEF,
  parameter int TRIG_WIDTH    = TRIG_WIDTH_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int WORD_TIMEOUT  = WORD_TIMEOUT_DEF,
  parameter int AW            = $clog2(MEM_SIZE)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  rd_xfr_sched_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(MEM_SIZE);
  localparam logic [15:0] TW_C     = 16'(TRIG_WIDTH);
  localparam logic [15:0] START_C  = 16'(START_TIMEOUT);
  localparam logic [15:0] WORD_C   = 16'(WORD_TIMEOUT);
  localparam int          PE_BIT   = stat_perr_bit(AW);
  localparam int          TO_BIT   = stat_to_bit(AW);

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_cnt;
  logic [AW:0]        r_wcnt, w_wcnt_inc;
  logic               r_buf, r_to, r_perr;
  logic               r_rd_en, r_wr_en, r_done;
  logic [AW:0]        r_wr_addr;
  logic [23:0]        r_wr_data;
  logic [7:0]         r_missed;
  logic               w_accept, w_miss, w_wr, w_to, w_trig_end, w_close;
  logic               w_sel, w_avail;
  logic [1:0]         w_full;
  logic [1:0][AW+2:0] w_stat_q;
  logic [AW+2:0]      w_stat;

  assign w_wcnt_inc = r_wcnt + 1'b1;
  assign w_close    = (r_state == S_CLOSE) && bus.enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // r_cnt holds the number of cycles since the last reference event
  // (acceptance, trigger fall or word strobe), so expiry is a plain equality.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_miss      = 1'b0;
    w_wr        = 1'b0;
    w_to        = 1'b0;
    w_trig_end  = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.evt_trig) begin
          if (w_avail) begin
            w_accept    = 1'b1;
            w_state_nxt = S_TRIG;
          end else begin
            w_miss = 1'b1;
          end
        end
        S_TRIG: if (r_cnt == TW_C) begin
          w_trig_end  = 1'b1;
          w_state_nxt = S_WAIT_FIRST;
        end
        S_WAIT_FIRST, S_XFER: begin
          if (bus.rx_valid) begin
            w_wr        = 1'b1;
            w_state_nxt = (w_wcnt_inc == FULL_CNT) ? S_CLOSE : S_XFER;
          end else if (r_cnt == ((r_state == S_WAIT_FIRST) ? START_C : WORD_C)) begin
            w_to        = 1'b1;
            w_state_nxt = S_CLOSE;
          end
        end
        S_CLOSE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_buf     <= 1'b0;
      r_to      <= 1'b0;
      r_perr    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_missed  <= '0;
    end else begin
      r_rd_en <= bus.enable;
      r_wr_en <= w_wr;
      r_done  <= w_close;
      if (w_miss && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
      if (w_accept) begin
        r_buf  <= w_sel;
        r_wcnt <= '0;
        r_to   <= 1'b0;
        r_perr <= 1'b0;
      end
      if (w_accept || w_wr || w_trig_end) r_cnt <= 16'd1;
      else if (r_state != S_IDLE)         r_cnt <= r_cnt + 16'd1;
      if (w_wr) begin
        r_wr_addr <= {r_buf, r_wcnt[AW-1:0]};
        r_wr_data <= {bus.rx_data1, bus.rx_data0};
        r_wcnt    <= w_wcnt_inc;
        r_perr    <= r_perr | (|bus.rx_perr);
      end
      if (w_to) r_to <= 1'b1;
    end
  end

  always_comb begin
    w_stat                           = '0;
    w_stat[STAT_CNT_LSB +: AW+1]     = r_wcnt;
    w_stat[PE_BIT]                   = r_perr;
    w_stat[TO_BIT]                   = r_to;
  end

  rd_buf_tracker #(.AW(AW)) u_trk (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_close      (w_close),
    .i_close_buf  (r_buf),
    .i_close_stat (w_stat),
    .i_release    (bus.buf_release),
    .o_full       (w_full),
    .o_stat       (w_stat_q),
    .o_sel        (w_sel),
    .o_avail      (w_avail)
  );

  assign bus.rd_enable  = r_rd_en;
  assign bus.rd_trigger = (r_state == S_TRIG);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.xfr_done   = r_done;
  assign bus.buf_full   = w_full;
  assign bus.buf_stat0  = w_stat_q[0];
  assign bus.buf_stat1  = w_stat_q[1];
  assign bus.missed_cnt = r_missed;

endmodule

// File: doc/rd_xfr_sched.md
# rd_xfr_sched

Transfer scheduler for the radio-detector (RD) serial link. It converts local event triggers into RD trigger pulses and arms the RD link. It sequences each returning transfer into one of two ping-pong capture buffers, with start and inter-word timeouts. It exposes per-buffer full/status flags that software releases. It sits between the trigger logic, the RD deserializer (one strobe per received 12-bit word pair) and the dual-port capture memory.

## Interface
Parameters:
- MEM_SIZE, 2048, words per transfer and per buffer; power of two.
- TRIG_WIDTH, 4, RD_TRIGGER high time in cycles; 1..15.
- START_TIMEOUT, 256, max cycles from RD_TRIGGER fall to first word.
- WORD_TIMEOUT, 64, max cycles between consecutive word strobes.
- AW, $clog2(MEM_SIZE), per-buffer address width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  RD interface enable, already synchronous to CLK.
- EVT_TRIG  in  1  single-cycle event trigger.
- RX_VALID  in  1  single-cycle strobe: a word pair has been received.
- RX_DATA0, RX_DATA1  in  12 each  received words for channels 0 and 1.
- RX_PERR  in  2  per-channel parity error, qualified by RX_VALID.
- BUF_RELEASE  in  2  single-cycle software release, one bit per buffer.
- RD_ENABLE  out  1  registered copy of ENABLE, sent to the RD.
- RD_TRIGGER  out  1  trigger pulse to the RD.
- WR_EN  out  1  capture memory write strobe.
- WR_ADDR  out  AW+1  {buffer index, word index}.
- WR_DATA  out  24  {RX_DATA1, RX_DATA0}.
- BUSY  out  1  high in every state except IDLE.
- XFR_DONE  out  1  single-cycle pulse when a buffer is marked full.
- BUF_FULL  out  2  per-buffer full flag.
- BUF_STAT0, BUF_STAT1  out  AW+3 each  {timeout, parity_err, word_count[AW:0]}.
- MISSED_CNT  out  8  count of dropped triggers; saturates at 255.

## Operation
- FSM states: IDLE, TRIG, WAIT_FIRST, XFER, CLOSE.
- IDLE -> TRIG when EVT_TRIG & ENABLE & a buffer is free.
  - Buffer choice: prefer the buffer other than the last one filled. If that buffer is full, use the free one.
- EVT_TRIG in IDLE with ENABLE=1 and both buffers full: trigger is dropped and MISSED_CNT increments.
- EVT_TRIG in any state other than IDLE: ignored and not counted.
- TRIG: RD_TRIGGER high for exactly TRIG_WIDTH cycles, then -> WAIT_FIRST with the timeout counter cleared.
- WAIT_FIRST:
  - first RX_VALID -> XFER; that word is written at index 0.
  - counter reaches START_TIMEOUT -> CLOSE with timeout=1 and word_count=0.
- XFER:
  - each RX_VALID writes at the current word index, increments word_count, ORs |RX_PERR into parity_err, and clears the gap counter.
  - word_count reaching MEM_SIZE -> CLOSE.
  - gap counter reaching WORD_TIMEOUT -> CLOSE with timeout=1.
- CLOSE (one cycle):
  - sets BUF_FULL for the active buffer, latches its BUF_STAT, pulses XFR_DONE, records it as last filled.
  - -> IDLE.
- RX_VALID outside WAIT_FIRST/XFER: ignored; no write.
- ENABLE=0 in any state:
  - next cycle -> IDLE; RD_TRIGGER drops.
  - active buffer is not marked full; BUF_STAT unchanged.
  - BUF_FULL flags of already-filled buffers are kept.
- BUF_RELEASE[i]: clears BUF_FULL[i] and BUF_STAT[i] next cycle.
  - Release of a non-full buffer has no effect; this includes the buffer being filled.
  - Release and CLOSE in the same cycle on different buffers: both take effect.
- word_count is AW+1 bits, so MEM_SIZE itself is representable. Word index is word_count[AW-1:0].

## Timing
- Reset values: all outputs 0, state IDLE, last-filled=1 (so buffer 0 is filled first), counters 0.
- RD_ENABLE: 1-cycle latency from ENABLE.
- EVT_TRIG at cycle n (accepted): RD_TRIGGER high during cycles n+1 .. n+TRIG_WIDTH.
- RX_VALID at cycle n: WR_EN/WR_ADDR/WR_DATA valid at cycle n+1, one-cycle pulse.
- Final word at cycle n: XFR_DONE and BUF_FULL at cycle n+2; BUSY low at n+2.
- Timeout counters count cycles after the reference event; expiry is detected on the cycle the count equals the parameter.
- Back-to-back: the earliest next trigger acceptance is the cycle XFR_DONE is high.

## Structure
- Package rd_xfr_pkg holds:
  - the state enum;
  - the BUF_STAT field offsets;
  - the default MEM_SIZE, TRIG_WIDTH and timeout constants.
- One sub-module, rd_buf_tracker, holds per-buffer full/status registers, the release handling and the next-buffer selection. The FSM and the counters stay in the top level.

## Test plan
- Reset, ENABLE=1, EVT_TRIG pulse, 2048 RX_VALID strobes every 13 cycles:
  - RD_TRIGGER high 4 cycles;
  - 2048 writes to addresses 0x000..0x7FF;
  - XFR_DONE once; BUF_FULL=01; BUF_STAT0 count=2048, flags 0.
- Two full transfers without release, then a third EVT_TRIG:
  - buffers filled 0 then 1; BUF_FULL=11;
  - no RD_TRIGGER; MISSED_CNT=1;
  - after BUF_RELEASE=01, the next trigger fills buffer 0.
- Trigger with no RX_VALID: CLOSE 256 cycles after RD_TRIGGER fall; BUF_STAT0 timeout=1, count=0.
- 100 words then silence: timeout=1 and count=100 after a 64-cycle gap; RX_PERR=10 on word 5 sets parity_err.
- ENABLE dropped at word 500: BUSY low within 2 cycles; BUF_FULL unchanged (00); no XFR_DONE; later RX_VALID produce no WR_EN.
- BUF_RELEASE[1] in the same cycle as CLOSE of buffer 0: buffer 1 cleared and buffer 0 set, final BUF_FULL=01. An EVT_TRIG during XFER is ignored and MISSED_CNT is unchanged.
